// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: MSB-first serial magnitude compare of two operands through an external 1-bit comparator
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             led_lt,
  output logic             led_eq,
  output logic             led_gt
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [IW-1:0]    idx;
  logic             oh, fin;
  always_comb begin
    cmp_a = (state == S_RUN) ? sa[idx] : 1'b0;
    cmp_b = (state == S_RUN) ? sb[idx] : 1'b0;
    oh    = $onehot({cmp_lt, cmp_eq, cmp_gt});
    fin   = !oh || !cmp_eq || idx == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      led_lt <= 1'b0;
      led_eq <= 1'b0;
      led_gt <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          idx   <= IW'(WIDTH - 1);
          busy  <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: if (fin) begin
          state                    <= S_DONE;
          busy                     <= 1'b0;
          done                     <= 1'b1;
          err                      <= !oh;
          {led_lt, led_eq, led_gt} <= oh ? {cmp_lt, cmp_eq, cmp_gt} : 3'b000;
        end else idx <= idx - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: scoreboard bench for the serial comparator sequencer with a behavioural 1-bit comparator
module tb_serial_compare_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst, start, fault;
  logic [W-1:0] a, b;
  logic cmp_a, cmp_b, cmp_lt, cmp_eq, cmp_gt;
  logic busy, done, err, led_lt, led_eq, led_gt;
  int checks = 0, errors = 0;
  typedef struct {logic [2:0] leds; logic err; int k;} exp_t;
  exp_t q[$];
  logic [W-1:0] cur_a, cur_b;
  logic [2:0] last_leds;
  logic last_err;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .err(err), .led_lt(led_lt), .led_eq(led_eq), .led_gt(led_gt)
  );

  always #5 clk = ~clk;
  // fault drives lt and gt together, which is never one-hot
  assign cmp_lt = fault | (~cmp_a & cmp_b);
  assign cmp_gt = fault | (cmp_a & ~cmp_b);
  assign cmp_eq = ~fault & (cmp_a == cmp_b);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [W-1:0] xa, xb, input int fault_at);
    exp_t e;
    e.k = W; e.leds = 3'b010; e.err = 1'b0;
    for (int i = W - 1; i >= 0; i--)
      if (xa[i] != xb[i]) begin
        e.k = W - i;
        e.leds = xa[i] ? 3'b001 : 3'b100;
        break;
      end
    if (fault_at > 0 && fault_at <= e.k) begin
      e.k = fault_at; e.leds = 3'b000; e.err = 1'b1;
    end
    q.push_back(e);
  endfunction

  task automatic accept(input logic [W-1:0] xa, xb, input int fault_at);
    a = xa; b = xb; start = 1'b1;
    cyc();
    start = 1'b0;
    cur_a = xa; cur_b = xb;
    push_exp(xa, xb, fault_at);
  endtask

  // called in the first cycle after the accept edge; returns in the done cycle
  task automatic wait_done(input bit noise, input int fault_at);
    int n;
    exp_t e;
    n = 1;
    while (done !== 1'b1 && n <= W + 2) begin
      fault = (n == fault_at);
      if (noise) begin start = 1'b1; a = W'($urandom); b = W'($urandom); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy run cycle %0d: got %b want 1", n, busy); end
      if (n <= W) begin
        checks++;
        if ({cmp_a, cmp_b} !== {cur_a[W-n], cur_b[W-n]}) begin
          errors++; $display("FAIL cmp bits run cycle %0d: got %b want %b", n, {cmp_a, cmp_b}, {cur_a[W-n], cur_b[W-n]});
        end
      end
      checks++;
      if ({led_lt, led_eq, led_gt, err} !== {last_leds, last_err}) begin
        errors++; $display("FAIL result hold run cycle %0d: got %b want %b", n, {led_lt, led_eq, led_gt, err}, {last_leds, last_err});
      end
      cyc();
      n++;
    end
    fault = 1'b0;
    e = q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done timeout: no done within %0d cycles", W + 2);
      return;
    end
    checks++;
    if (n != e.k + 1) begin errors++; $display("FAIL done latency: got cycle %0d want %0d", n, e.k + 1); end
    checks++;
    if ({led_lt, led_eq, led_gt} !== e.leds) begin errors++; $display("FAIL leds: got %b want %b", {led_lt, led_eq, led_gt}, e.leds); end
    checks++;
    if (err !== e.err) begin errors++; $display("FAIL err: got %b want %b", err, e.err); end
    checks++;
    if ({busy, cmp_a, cmp_b} !== 3'b000) begin errors++; $display("FAIL done-cycle busy/cmp: got %b want 000", {busy, cmp_a, cmp_b}); end
    last_leds = e.leds; last_err = e.err;
  endtask

  task automatic run_op(input logic [W-1:0] xa, xb);
    accept(xa, xb, 0);
    wait_done(1'b0, 0);
    cyc();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done pulse width: got done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; fault = 1'b0;
    cyc(); cyc();
    checks++;
    if ({busy, done, err, led_lt, led_eq, led_gt, cmp_a, cmp_b} !== 8'h00) begin
      errors++; $display("FAIL reset outputs: got %b want 00000000", {busy, done, err, led_lt, led_eq, led_gt, cmp_a, cmp_b});
    end
    rst = 1'b0;
    last_leds = 3'b000; last_err = 1'b0;
    cyc();
  endtask

  task automatic test_equal();      run_op(8'hA5, 8'hA5); endtask
  task automatic test_msb_exit();   run_op(8'h80, 8'h7F); endtask
  task automatic test_lsb_exit_hold();
    run_op(8'h10, 8'h11);
    run_op(8'h00, 8'h00);
  endtask

  task automatic test_ignored_start();
    a = 8'hC3; b = 8'hC7; start = 1'b1;
    cyc();
    cur_a = 8'hC3; cur_b = 8'hC7;
    push_exp(8'hC3, 8'hC7, 0);
    wait_done(1'b1, 0);
    a = 8'h0F; b = 8'h0E;
    cyc();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL retrigger idle cycle: got done,busy=%b want 00", {done, busy}); end
    cyc();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL retrigger accept: got busy=%b want 1", busy); end
    cur_a = 8'h0F; cur_b = 8'h0E;
    push_exp(8'h0F, 8'h0E, 0);
    wait_done(1'b0, 0);
    cyc();
  endtask

  task automatic test_fault();
    accept(8'h3C, 8'h3C, 3);
    wait_done(1'b0, 3);
    cyc();
    run_op(8'h01, 8'h02);
  endtask

  task automatic test_reset_mid_run();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({busy, done, err, led_lt, led_eq, led_gt, cmp_a, cmp_b} !== 8'h00) begin
      errors++; $display("FAIL mid-run reset outputs: got %b want 00000000", {busy, done, err, led_lt, led_eq, led_gt, cmp_a, cmp_b});
    end
    rst = 1'b0;
    last_leds = 3'b000; last_err = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      cyc();
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL post-reset quiet cycle %0d: got done,busy=%b want 00", i, {done, busy}); end
    end
    run_op(8'h5A, 8'h5B);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] xa, xb;
      xa = W'($urandom);
      xb = (i % 3 == 0) ? xa : W'($urandom);
      accept(xa, xb, 0);
      wait_done(1'b0, 0);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_equal();
    test_msb_exit();
    test_lsb_exit_hold();
    test_ignored_start();
    test_fault();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
